lvdc_int_scheduler: RTL

- Collects asynchronous external interrupt requests, prioritises them and presents one interrupt at a time to the op-code register (INT) at an instruction boundary.
- Holds that interrupt until the program acknowledges it through INTCV.
- Sits between the external interrupt lines and a1a12/a1a15.
- Its mask is loaded from the transfer register by a PIO-decoded write strobe.

---
 rtl/lvdc_int_scheduler.sv | 119 +++++++++++
 1 files changed

// File: rtl/lvdc_int_scheduler.sv
// Interrupt scheduler: synchronises external requests, latches pending events,
// and presents the highest-priority unmasked one to the op-code register at an instruction boundary.
module lvdc_int_scheduler #(
  parameter int unsigned NREQ        = 8,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            BOP,
  input  logic            CSTN,
  input  logic [NREQ-1:0] IRQ,
  input  logic            MASK_WE,
  input  logic [NREQ-1:0] MASK_DATA,
  input  logic            PHASE_END,
  input  logic            INHV,
  input  logic            INTCV,
  output logic            INT,
  output logic [IDW-1:0]  INT_ID,
  output logic [NREQ-1:0] PEND,
  output logic [NREQ-1:0] MASK,
  output logic [NREQ-1:0] OVR,
  output logic            BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t                           state_q, state_d;
  logic [SYNC_STAGES-1:0][NREQ-1:0] sync_q;
  logic [NREQ-1:0]                  edge_q;
  logic [NREQ-1:0]                  rise_c;
  logic [NREQ-1:0]                  eligible_c;
  logic [IDW-1:0]                   winner_c;
  logic                             take_c;
  logic [NREQ-1:0]                  clr_c;
  logic [NREQ-1:0]                  pend_d;
  logic [NREQ-1:0]                  ovr_d;

  // Synchroniser chain followed by a single edge flop per line.
  always_ff @(posedge BOP or negedge CSTN) begin
    if (!CSTN) begin
      sync_q <= '0;
      edge_q <= '0;
    end else begin
      sync_q[0] <= IRQ;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c     = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign eligible_c = PEND & ~MASK;

  // Lowest set index wins.
  always_comb begin
    logic found;
    winner_c = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (eligible_c[i] && !found) begin
        winner_c = IDW'(i);
        found    = 1'b1;
      end
    end
  end

  // Next-state, take decision and pending/overrun updates.
  always_comb begin
    state_d = state_q;
    take_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((|eligible_c) && !INHV) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!(|eligible_c) || INHV) begin
          state_d = ST_IDLE;
        end else if (PHASE_END) begin
          state_d = ST_SERVICE;
          take_c  = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (INTCV) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    clr_c  = take_c ? (NREQ'(1) << winner_c) : '0;
    // A new event on the line being taken keeps it pending and is not an overrun.
    pend_d = (PEND & ~clr_c) | rise_c;
    ovr_d  = (OVR & ~clr_c) | (rise_c & PEND & ~clr_c);
  end

  always_ff @(posedge BOP or negedge CSTN) begin
    if (!CSTN) begin
      state_q <= ST_IDLE;
      INT     <= 1'b0;
      INT_ID  <= '0;
      PEND    <= '0;
      OVR     <= '0;
      MASK    <= '1;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_d;
      INT     <= (state_d == ST_SERVICE);
      BUSY    <= (state_d != ST_IDLE);
      PEND    <= pend_d;
      OVR     <= ovr_d;
      if (take_c)  INT_ID <= winner_c;
      if (MASK_WE) MASK   <= MASK_DATA;
    end
  end

endmodule
